lfsr_word_server: RTL and testbench

Controller that shares one 8-bit Fibonacci LFSR between up to NREQ requesters. It arbitrates requests round-robin, clocks the LFSR exactly 8 times per grant to assemble one pseudo-random byte from the serial output bit, and returns that byte with a one-cycle grant pulse. It also handles seed loading. It sits between the LFSR datapath and its consumers, so no consumer drives the LFSR directly.

---
 rtl/lfsr_word_server_if.sv | 11 +
 rtl/lfsr_word_server.sv | 68 ++++++
 tb/tb_lfsr_word_server.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lfsr_word_server_if.sv
// lfsr_word_server_if: request/grant/seed bundle between the LFSR word server and its consumers
interface lfsr_word_server_if #(parameter int NREQ = 4);
  logic            seed_valid;
  logic [7:0]      seed;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [7:0]      data;
  logic            busy;
  modport master (output seed_valid, seed, req, input gnt, data, busy);
  modport slave  (input seed_valid, seed, req, output gnt, data, busy);
endinterface

// File: rtl/lfsr_word_server.sv
// lfsr_word_server: round-robin shares one 8-bit Fibonacci LFSR, delivering one byte per grant
module lfsr_word_server #(parameter int NREQ = 4) (
  input logic clk,
  input logic rst,
  lfsr_word_server_if.slave io_bus
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, GEN, DELIVER} state_t;
  state_t          r_state, w_next;
  logic [7:0]      r_q, r_word, r_data, w_word_nx;
  logic [NREQ-1:0] r_gnt;
  logic [PW-1:0]   r_ptr, r_win, w_win, w_idx;
  logic [2:0]      r_cnt;
  logic            w_fb, w_take;
  assign w_fb      = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];
  assign w_word_nx = {r_word[6:0], r_q[7]};
  assign w_take    = (r_state == IDLE) && !io_bus.seed_valid && |io_bus.req;
  // scan from the far end so the closest set bit after ptr is assigned last
  always_comb begin
    w_win = r_ptr;
    w_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = PW'((int'(r_ptr) + i) % NREQ);
      if (io_bus.req[w_idx]) w_win = w_idx;
    end
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_take ? GEN : IDLE)
           : (r_state == GEN)  ? ((r_cnt == 3'd7) ? DELIVER : GEN)
           : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= 8'h01;
      r_word <= '0;
      r_data <= '0;
      r_gnt  <= '0;
      r_ptr  <= '0;
      r_win  <= '0;
      r_cnt  <= '0;
    end else begin
      r_gnt <= '0;
      if (r_state == IDLE && io_bus.seed_valid) r_q <= (io_bus.seed == 8'h00) ? 8'h01 : io_bus.seed;
      if (w_take) begin
        r_win <= w_win;
        r_cnt <= '0;
      end
      if (r_state == GEN) begin
        r_q    <= {r_q[6:0], w_fb};
        r_word <= w_word_nx;
        r_cnt  <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_gnt  <= NREQ'(1) << r_win;
          r_data <= w_word_nx;
        end
      end
      if (r_state == DELIVER) r_ptr <= (r_win == PW'(NREQ - 1)) ? '0 : r_win + 1'b1;
    end
  end
  assign io_bus.gnt  = r_gnt;
  assign io_bus.data = r_data;
  assign io_bus.busy = (r_state != IDLE);
endmodule

// File: tb/tb_lfsr_word_server.sv
// tb_lfsr_word_server: directed scoreboard bench for the shared-LFSR word server
module tb_lfsr_word_server;
  typedef struct packed {logic [3:0] g; logic [7:0] d;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [7:0] m_q = 8'h01;
  int   m_ptr = 0;
  exp_t sb[$];
  lfsr_word_server_if #(.NREQ(4)) bus ();
  lfsr_word_server #(.NREQ(4)) dut (.clk(clk), .rst(rst), .io_bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [3:0] r);
    int w;
    exp_t e;
    w = 0;
    for (int i = 3; i >= 0; i--) if (r[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
    e.g = 4'(1 << w);
    e.d = m_q;
    sb.push_back(e);
    for (int i = 0; i < 8; i++) m_q = {m_q[6:0], m_q[7] ^ m_q[5] ^ m_q[4] ^ m_q[3]};
    m_ptr = (w + 1) % 4;
  endtask
  task automatic model_reset();
    m_q = 8'h01;
    m_ptr = 0;
  endtask
  task automatic expect_grant(input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 16'd1, 16'd0);
      return;
    end
    e = sb.pop_front();
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      if (n > lat - 9) chk("busy", 16'(bus.busy), 16'd1);
      if (n < lat) chk("early_gnt", 16'(bus.gnt), 16'd0);
    end
    chk("gnt", 16'(bus.gnt), 16'(e.g));
    chk("data", 16'(bus.data), 16'(e.d));
  endtask
  initial begin
    bus.seed_valid = 1'b0;
    bus.seed = 8'h00;
    bus.req = 4'b0000;
    @(negedge clk);
    chk("rst_gnt", 16'(bus.gnt), 16'd0);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_data", 16'(bus.data), 16'd0);
    rst = 1'b0;
    // single requester held: 01 then 1C
    bus.req = 4'b0001;
    push(4'b0001);
    push(4'b0001);
    expect_grant(9);
    expect_grant(10);
    bus.req = 4'b0000;
    // fresh round-robin sweep
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) push(4'b1111);
    expect_grant(9);
    for (int i = 0; i < 4; i++) expect_grant(10);
    bus.req = 4'b0000;
    @(negedge clk);
    // zero seed beats a simultaneous request
    bus.seed_valid = 1'b1;
    bus.seed = 8'h00;
    bus.req = 4'b0100;
    @(negedge clk);
    chk("seed_no_gen", 16'(bus.busy), 16'd0);
    m_q = 8'h01;
    bus.seed_valid = 1'b0;
    push(4'b0100);
    expect_grant(9);
    bus.req = 4'b0000;
    @(negedge clk);
    // seed while busy is ignored; dropped req still gets its word
    bus.req = 4'b0010;
    push(4'b0010);
    @(negedge clk);
    bus.req = 4'b0000;
    bus.seed_valid = 1'b1;
    bus.seed = 8'hA5;
    expect_grant(8);
    bus.seed_valid = 1'b0;
    @(negedge clk);
    bus.seed_valid = 1'b1;
    @(negedge clk);
    bus.seed_valid = 1'b0;
    m_q = 8'hA5;
    bus.req = 4'b0011;
    push(4'b0011);
    expect_grant(9);
    bus.req = 4'b0000;
    @(negedge clk);
    // asynchronous reset in the middle of GEN
    bus.req = 4'b1010;
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_gnt", 16'(bus.gnt), 16'd0);
    chk("abort_busy", 16'(bus.busy), 16'd0);
    chk("abort_data", 16'(bus.data), 16'd0);
    model_reset();
    @(negedge clk);
    chk("abort_stray", 16'(bus.gnt), 16'd0);
    rst = 1'b0;
    push(4'b1010);
    expect_grant(9);
    bus.req = 4'b0000;
    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
